// File: rtl/aes_pkg.sv
// Shared constants and types for the AES output serializer slice.
// Block width, serializer FSM states and word-count helper.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  function automatic int nwords(input int word_w);
    return AES_BLOCK_W / word_w;
  endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// Small FIFO of 128-bit ciphertext blocks with wrap-bit pointers.
// A write while full is accepted only when a read happens in the same cycle.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AES_BLOCK_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [AES_BLOCK_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AES_BLOCK_W-1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   do_wr;
  logic                   do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/aes_out_serializer.sv
// Captures each AES ciphertext once per valid rising edge, buffers it and
// streams it out as WORD_W-bit words over a valid/ready handshake.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter bit MSW_FIRST  = 1'b1
) (
  input  logic                        AES_clk,
  input  logic                        AES_rst_n,
  input  logic                        AES_data_out_valid,
  input  logic [AES_BLOCK_W-1:0]      AES_data_out,
  input  logic                        ser_ready,
  output logic                        ser_valid,
  output logic [WORD_W-1:0]           ser_data,
  output logic                        ser_last,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        ovf_err,
  input  logic                        ovf_clr
);

  localparam int NWORDS = nwords(WORD_W);
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  ser_state_e             state;
  ser_state_e             state_next;
  logic                   valid_d;
  logic                   capture;
  logic                   overflow;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [AES_BLOCK_W-1:0] fifo_head;
  logic [AES_BLOCK_W-1:0] shreg;
  logic [IDX_W-1:0]       word_idx;
  logic                   load;
  logic                   advance;
  logic                   at_last;

  // A level-held valid only captures on its rising edge.
  assign capture  = AES_data_out_valid & ~valid_d;
  assign overflow = capture & fifo_full & ~fifo_pop;

  aes_block_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (AES_clk),
    .rst_n  (AES_rst_n),
    .wr_en  (capture),
    .wr_data(AES_data_out),
    .rd_en  (fifo_pop),
    .rd_data(fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state   <= IDLE;
      valid_d <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      state   <= state_next;
      valid_d <= AES_data_out_valid;
      if (overflow)     ovf_err <= 1'b1;
      else if (ovf_clr) ovf_err <= 1'b0;
    end
  end

  assign at_last = (word_idx == LAST_IDX);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (ser_ready) begin
          if (!at_last) begin
            advance = 1'b1;
          end else if (!fifo_empty) begin
            // Back-to-back reload keeps the stream free of bubbles.
            fifo_pop = 1'b1;
            load     = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      shreg    <= '0;
      word_idx <= '0;
    end else if (load) begin
      shreg    <= fifo_head;
      word_idx <= '0;
    end else if (advance) begin
      shreg    <= MSW_FIRST ? (shreg << WORD_W) : (shreg >> WORD_W);
      word_idx <= word_idx + 1'b1;
    end
  end

  assign ser_valid = (state == SEND);
  assign ser_last  = ser_valid & at_last;
  assign ser_data  = MSW_FIRST ? shreg[AES_BLOCK_W-1 -: WORD_W] : shreg[WORD_W-1:0];

endmodule

// File: tb/tb_aes_out_serializer.sv
// Scoreboard bench for aes_out_serializer (WORD_W=32, FIFO_DEPTH=2, MSW first).
// Stimulus pushes expected words; a negedge monitor pops and compares transfers.
module tb_aes_out_serializer;
  import aes_pkg::*;

  localparam int WORD_W = 32;
  localparam int NW     = 4;
  localparam logic [127:0] D = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic [127:0]      din;
  logic              ready;
  logic              ser_valid;
  logic [WORD_W-1:0] ser_data;
  logic              ser_last;
  logic [1:0]        fifo_level;
  logic              ovf_err;
  logic              ovf_clr;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  int                n_checks = 0;
  int                n_pass   = 0;
  logic              prev_stall;
  logic [WORD_W-1:0] prev_data;
  logic              prev_last;

  aes_out_serializer #(
    .WORD_W    (WORD_W),
    .FIFO_DEPTH(2),
    .MSW_FIRST (1'b1)
  ) dut (
    .AES_clk           (clk),
    .AES_rst_n         (rst_n),
    .AES_data_out_valid(valid),
    .AES_data_out      (din),
    .ser_ready         (ready),
    .ser_valid         (ser_valid),
    .ser_data          (ser_data),
    .ser_last          (ser_last),
    .fifo_level        (fifo_level),
    .ovf_err           (ovf_err),
    .ovf_clr           (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_block(input logic [127:0] d);
    exp_t e;
    for (int i = 0; i < NW; i++) begin
      e.data = d[127 - WORD_W*i -: WORD_W];
      e.last = (i == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  // Single-cycle valid pulse followed by one low cycle so the next rise is seen.
  task automatic pulse(input logic [127:0] d);
    valid = 1'b1;
    din   = d;
    tick();
    valid = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || ser_valid) && k < budget) begin
      tick();
      k++;
    end
    check("drain_pending", 128'(exp_q.size()), 128'(0));
    check("drain_valid", 128'(ser_valid), 128'(0));
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!ser_valid && k < budget) begin
      tick();
      k++;
    end
    check("wait_valid", 128'(ser_valid), 128'(1));
  endtask

  // Monitor: scores every transfer and checks that stalled words hold still.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 128'(ser_valid), 128'(1));
        check("stall_hold_data", 128'(ser_data), 128'(prev_data));
        check("stall_hold_last", 128'(ser_last), 128'(prev_last));
      end
      if (ser_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", 128'(ser_valid), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", 128'(ser_data), 128'(mon_e.data));
          check("word_last", 128'(ser_last), 128'(mon_e.last));
        end
      end
      prev_stall = ser_valid && !ready;
      prev_data  = ser_data;
      prev_last  = ser_last;
    end
  end

  initial begin
    rst_n   = 1'b0;
    valid   = 1'b0;
    din     = '0;
    ready   = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(ser_valid), 128'(0));
    check("rst_data", 128'(ser_data), 128'(0));
    check("rst_last", 128'(ser_last), 128'(0));
    check("rst_level", 128'(fifo_level), 128'(0));
    check("rst_ovf", 128'(ovf_err), 128'(0));
    rst_n = 1'b1;
    tick();

    // 1: single pulse, two-cycle latency, four back-to-back words
    ready = 1'b1;
    valid = 1'b1;
    din   = D;
    expect_block(D);
    tick();
    valid = 1'b0;
    @(negedge clk) check("lat_capture_cycle", 128'(ser_valid), 128'(0));
    @(negedge clk) check("lat_first_word", 128'(ser_valid), 128'(1));
    repeat (NW - 1) @(negedge clk) check("burst_valid", 128'(ser_valid), 128'(1));
    @(negedge clk) check("burst_end", 128'(ser_valid), 128'(0));
    tick();
    wait_idle(20);

    // 2: valid held high for 51 cycles captures once
    valid = 1'b1;
    din   = D;
    expect_block(D);
    repeat (51) tick();
    valid = 1'b0;
    tick();
    wait_idle(20);
    check("held_level", 128'(fifo_level), 128'(0));

    // 3: ready toggling 0,1,0,1 gives four transfers over eight cycles
    ready = 1'b0;
    expect_block(D);
    pulse(D);
    wait_valid(10);
    for (int i = 0; i < 8; i++) begin
      ready = i[0];
      tick();
    end
    check("toggle_done_valid", 128'(ser_valid), 128'(0));
    check("toggle_done_queue", 128'(exp_q.size()), 128'(0));
    ready = 1'b1;
    wait_idle(20);

    // 4: stalled sink; shifter plus two FIFO slots hold three blocks
    ready = 1'b0;
    expect_block(D);
    pulse(D);
    expect_block(~D);
    pulse(~D);
    expect_block(D ^ 128'd1);
    pulse(D ^ 128'd1);
    check("full_level", 128'(fifo_level), 128'(2));
    check("full_no_ovf", 128'(ovf_err), 128'(0));
    pulse(D ^ 128'd2);
    check("ovf_set", 128'(ovf_err), 128'(1));
    check("ovf_level", 128'(fifo_level), 128'(2));
    valid   = 1'b1;
    din     = D ^ 128'd3;
    ovf_clr = 1'b1;
    tick();
    valid   = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", 128'(ovf_err), 128'(1));
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 128'(ovf_err), 128'(0));
    // Capture lands on the edge of the last-word transfer: full FIFO with a pop.
    ready = 1'b1;
    repeat (NW - 1) tick();
    valid = 1'b1;
    din   = D ^ 128'd4;
    expect_block(D ^ 128'd4);
    tick();
    valid = 1'b0;
    check("full_pop_level", 128'(fifo_level), 128'(2));
    check("full_pop_no_ovf", 128'(ovf_err), 128'(0));
    tick();
    wait_idle(60);

    // 5: two queued blocks drain as eight words without a bubble
    ready = 1'b0;
    expect_block(D);
    pulse(D);
    expect_block(~D);
    pulse(~D);
    ready = 1'b1;
    repeat (2 * NW) @(negedge clk) check("nobubble_valid", 128'(ser_valid), 128'(1));
    @(negedge clk) check("nobubble_end", 128'(ser_valid), 128'(0));
    tick();
    wait_idle(20);

    // 6: reset after two words discards the rest of the block
    ready = 1'b1;
    mon_e.data = D[127 -: WORD_W];
    mon_e.last = 1'b0;
    exp_q.push_back(mon_e);
    mon_e.data = D[95 -: WORD_W];
    exp_q.push_back(mon_e);
    pulse(D);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(ser_valid), 128'(0));
    check("midrst_level", 128'(fifo_level), 128'(0));
    check("midrst_ovf", 128'(ovf_err), 128'(0));
    check("midrst_data", 128'(ser_data), 128'(0));
    check("midrst_queue", 128'(exp_q.size()), 128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    expect_block(D);
    pulse(D);
    wait_idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
